mmio_uart_transmitter: RTL and testbench

- Memory-mapped UART transmitter; a responder on the phoeniX data memory interface.
- Turns the console characters that firmware writes (printf path at 32'h1000_0000) into a serial 8N1 bitstream on a real pin.
- Holds writes in a FIFO and exposes a status word so firmware can poll before writing.
- Sits beside data memory; the address decode in front of it routes BASE_ADDRESS..BASE_ADDRESS+7 here.

---
 rtl/mmio_uart_transmitter.sv | 187 ++++++++++++++++++
 tb/tb_mmio_uart_transmitter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_transmitter.sv
// Memory-mapped 8N1 UART transmitter on the phoeniX data memory interface.
// Writes to TXDATA queue bytes in a FIFO; STATUS lets firmware poll before writing.
`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

module mmio_uart_transmitter #(
   parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
   parameter int          CLK_PER_BIT  = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_memory_interface_enable,
   input  logic        data_memory_interface_state,
   input  logic [31:0] data_memory_interface_address,
   input  logic [3:0]  data_memory_interface_frame_mask,
   inout  wire  [31:0] data_memory_interface_data,
   output logic        uart_tx,
   output logic        tx_busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CLK_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   tx_state_t        state, state_next;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
   logic [2:0]       bit_idx, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             tx_next;
   logic             pop;

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   fifo_count;
   logic             fifo_empty, fifo_full, overflow;

   logic             hit, sel_status, is_write, is_read;
   logic             push_req, push_ok, clear_overflow, bit_end;
   logic [31:0]      count_ext, status_word, read_data;
   logic [4:0]       status_count;
   logic             unused_bits;

   assign hit        = data_memory_interface_enable &&
                       (data_memory_interface_address[31:3] == BASE_ADDRESS[31:3]);
   assign sel_status = data_memory_interface_address[2];
   assign is_write   = hit && (data_memory_interface_state == `WRITE);
   assign is_read    = hit && (data_memory_interface_state == `READ);

   assign push_req       = is_write && !sel_status && data_memory_interface_frame_mask[3];
   assign clear_overflow = is_write && sel_status && data_memory_interface_frame_mask[2] &&
                           data_memory_interface_data[8];

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
   // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
   assign push_ok    = push_req && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= data_memory_interface_data[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (clear_overflow)             overflow <= 1'b0;
         else if (push_req && !push_ok)  overflow <= 1'b1;
      end
   end

   assign bit_end = (bit_cnt == CNT_W'(CLK_PER_BIT - 1));

   // The next line level is computed here and registered, so uart_tx never glitches.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift_reg;
      tx_next      = uart_tx;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               pop          = 1'b1;
               shift_next   = fifo_mem[rd_ptr];
               bit_cnt_next = '0;
               state_next   = START;
               tx_next      = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               bit_cnt_next = '0;
               bit_idx_next = '0;
               state_next   = DATA;
               tx_next      = shift_reg[0];
            end else begin
               bit_cnt_next = bit_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               bit_cnt_next = '0;
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  shift_next   = {1'b0, shift_reg[7:1]};
                  tx_next      = shift_reg[1];
               end
            end else begin
               bit_cnt_next = bit_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               bit_cnt_next = '0;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_mem[rd_ptr];
                  state_next = START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = IDLE;
                  tx_next    = 1'b1;
               end
            end else begin
               bit_cnt_next = bit_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         uart_tx   <= 1'b1;
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_next;
         uart_tx   <= tx_next;
      end
   end

   assign tx_busy = (state != IDLE) || !fifo_empty;

   assign count_ext    = 32'(fifo_count);
   assign status_count = (count_ext > 32'd31) ? 5'd31 : count_ext[4:0];
   assign status_word  = {23'b0, overflow, status_count, fifo_empty, fifo_full, tx_busy};
   assign read_data    = sel_status ? status_word : 32'h0;

   assign data_memory_interface_data = (is_read && reset) ? read_data : 32'bz;

   assign unused_bits = ^{data_memory_interface_address[1:0],
                          data_memory_interface_frame_mask[1:0],
                          data_memory_interface_data[31:9], count_ext[31:5]};

endmodule

// File: tb/tb_mmio_uart_transmitter.sv
// Bench for mmio_uart_transmitter: a serial-line receiver decodes every frame
// and checks it against a queue of bytes the stimulus expects to be sent.
`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

module tb_mmio_uart_transmitter;

   localparam int          C    = 4;
   localparam int          D    = 8;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        st = `READ;
   logic [31:0] addr = '0;
   logic [3:0]  mask = '0;
   logic [31:0] drv_val = '0;
   logic        drv_en = 1'b0;
   wire  [31:0] bus;
   logic        uart_tx, tx_busy;

   assign bus = drv_en ? drv_val : 32'bz;

   mmio_uart_transmitter #(
      .BASE_ADDRESS(BASE),
      .CLK_PER_BIT (C),
      .FIFO_DEPTH  (D)
   ) dut (
      .clk                             (clk),
      .reset                           (reset),
      .data_memory_interface_enable    (en),
      .data_memory_interface_state     (st),
      .data_memory_interface_address   (addr),
      .data_memory_interface_frame_mask(mask),
      .data_memory_interface_data      (bus),
      .uart_tx                         (uart_tx),
      .tx_busy                         (tx_busy)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle++;

   int         n_compared = 0;
   int         n_mismatched = 0;
   logic [7:0] exp_q[$];
   int         start_cycles[$];

   function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [3:0] m,
                                input logic [31:0] d);
      en = 1'b1; st = wr ? `WRITE : `READ; addr = a; mask = m; drv_val = d; drv_en = wr;
      @(posedge clk);
      #1;
      en = 1'b0; drv_en = 1'b0;
   endtask

   task automatic readBus(input logic [31:0] a, input logic e, output logic [31:0] v);
      en = e; st = `READ; addr = a; mask = 4'b1111; drv_en = 1'b0;
      #1;
      v = bus;
      en = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitDrain(input int bound);
      int i = 0;
      while ((exp_q.size() != 0 || tx_busy) && i < bound) begin
         @(posedge clk);
         #1;
         i++;
      end
      if (i >= bound) checkOutput("drain_timeout", exp_q.size(), 0);
   endtask

   // Line receiver: samples each bit mid-cell; frames cut short by reset are discarded.
   initial begin : monitor
      logic [9:0] bits;
      logic       aborted;
      forever begin
         @(negedge clk);
         if (reset && uart_tx == 1'b0) begin
            start_cycles.push_back(cycle);
            aborted = 1'b0;
            bits    = '0;
            for (int k = 0; k < 10 * C; k++) begin
               if (!reset) aborted = 1'b1;
               if (k % C == C / 2) bits[k / C] = uart_tx;
               if (k < 10 * C - 1) @(negedge clk);
            end
            if (!aborted) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_frame", {24'b0, bits[8:1]}, 32'hFFFF_FFFF);
               end else begin
                  checkOutput("start_bit", {31'b0, bits[0]}, 32'd0);
                  checkOutput("frame_byte", {24'b0, bits[8:1]}, {24'b0, exp_q.pop_front()});
                  checkOutput("stop_bit", {31'b0, bits[9]}, 32'd1);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin : stimulus
      logic [31:0] v;
      logic [31:0] r;
      logic [7:0]  b;
      logic [3:0]  m;
      int          n, gap;

      waitCycles(3);
      reset = 1'b1;
      checkOutput("reset_tx", {31'b0, uart_tx}, 32'd1);
      checkOutput("reset_busy", {31'b0, tx_busy}, 32'd0);
      readBus(BASE + 4, 1'b1, v);
      checkOutput("reset_status", v, 32'h4);

      // Single byte timing
      exp_q.push_back(8'h41);
      applyStimulus(1'b1, BASE, 4'b1000, 32'h0000_0041);
      checkOutput("tx_before_start", {31'b0, uart_tx}, 32'd1);
      checkOutput("busy_after_push", {31'b0, tx_busy}, 32'd1);
      waitCycles(1);
      checkOutput("start_first", {31'b0, uart_tx}, 32'd0);
      waitCycles(3);
      checkOutput("start_last", {31'b0, uart_tx}, 32'd0);
      waitCycles(1);
      checkOutput("data_bit0", {31'b0, uart_tx}, 32'd1);
      waitCycles(35);
      checkOutput("busy_last_stop", {31'b0, tx_busy}, 32'd1);
      checkOutput("tx_last_stop", {31'b0, uart_tx}, 32'd1);
      waitCycles(1);
      checkOutput("busy_after_frame", {31'b0, tx_busy}, 32'd0);
      waitCycles(2);

      // Back-to-back frames
      start_cycles.delete();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      applyStimulus(1'b1, BASE, 4'b1000, 32'h55);
      applyStimulus(1'b1, BASE, 4'b1000, 32'hAA);
      waitDrain(200);
      checkOutput("b2b_frames", start_cycles.size(), 2);
      checkOutput("b2b_gap", (start_cycles.size() >= 2) ? start_cycles[1] - start_cycles[0] : -1, 40);

      // Overflow while a frame is on the line
      exp_q.push_back(8'h30);
      applyStimulus(1'b1, BASE, 4'b1000, 32'h30);
      waitCycles(3);
      for (int i = 1; i <= 9; i++) begin
         if (i <= D) exp_q.push_back(8'(8'h30 + i));
         applyStimulus(1'b1, BASE + 1, 4'b1000, 32'(8'h30 + i));
      end
      readBus(BASE + 4, 1'b1, v);
      checkOutput("status_overflow", v, 32'h143);
      readBus(BASE, 1'b1, v);
      checkOutput("txdata_read", v, 32'h0);
      readBus(BASE + 4, 1'b0, v);
      checkOutput("hiz_enable_low", {31'b0, (v === 32'bz) || (v === 32'h0)}, 32'd1);
      readBus(BASE + 32'h10, 1'b1, v);
      checkOutput("hiz_miss_10", {31'b0, (v === 32'bz) || (v === 32'h0)}, 32'd1);
      readBus(BASE + 32'h14, 1'b1, v);
      checkOutput("hiz_miss_14", {31'b0, (v === 32'bz) || (v === 32'h0)}, 32'd1);
      applyStimulus(1'b1, BASE + 4, 4'b0100, 32'h0000_0100);
      readBus(BASE + 4, 1'b1, v);
      checkOutput("status_ovf_cleared", v, 32'h043);
      waitDrain(9 * 10 * C + 50);
      waitCycles(2);
      readBus(BASE + 4, 1'b1, v);
      checkOutput("status_idle", v, 32'h4);

      // Write with byte lane 0 off is ignored
      applyStimulus(1'b1, BASE, 4'b0001, 32'h5A5A_5A5A);
      waitCycles(3);
      checkOutput("mask_ignore_tx", {31'b0, uart_tx}, 32'd1);
      readBus(BASE + 4, 1'b1, v);
      checkOutput("mask_ignore_status", v, 32'h4);

      // Reset during the data bits drops the frame and the queued bytes
      applyStimulus(1'b1, BASE, 4'b1000, 32'h77);
      applyStimulus(1'b1, BASE, 4'b1000, 32'h12);
      applyStimulus(1'b1, BASE, 4'b1000, 32'h34);
      waitCycles(8);
      reset = 1'b0;
      waitCycles(1);
      reset = 1'b1;
      checkOutput("abort_tx", {31'b0, uart_tx}, 32'd1);
      readBus(BASE + 4, 1'b1, v);
      checkOutput("abort_status", v, 32'h4);
      waitCycles(100);
      checkOutput("abort_quiet", {31'b0, uart_tx}, 32'd1);

      // Randomized bursts that never exceed the FIFO
      for (int round = 0; round < 6; round++) begin
         n = $urandom_range(1, D);
         for (int i = 0; i < n; i++) begin
            r = $urandom();
            b = 8'($urandom_range(0, 255));
            m = 4'($urandom_range(0, 15));
            if (m[3]) exp_q.push_back(b);
            applyStimulus(1'b1, BASE + 32'($urandom_range(0, 3)), m, {r[31:8], b});
            gap = $urandom_range(0, 2);
            if (gap > 0) waitCycles(gap);
         end
         waitDrain(n * 10 * C + 100);
         waitCycles(2);
         readBus(BASE + 4, 1'b1, v);
         checkOutput("status_round", v, 32'h4);
      end

      waitCycles(5);
      checkOutput("leftover_expected", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
